// File: rtl/table_mem_arbiter.sv
// Round-robin, burst-locked arbiter for a single shared table-memory port.
// Define ARB_WATCHDOG_EN to add the per-grant hold watchdog (revoke + sticky timeout_o).
module table_mem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 64,
  parameter int ADDR_BUS = 16,
  parameter int DATA_BUS = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_ce_i,
  input  logic [NUM_REQ-1:0]                 req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_BUS-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][3:0]            req_width_i,
  input  logic [NUM_REQ-1:0][DATA_BUS-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic [DATA_BUS-1:0]                rd_data_o,
  output logic                               mem_ce_o,
  output logic                               mem_we_o,
  output logic [ADDR_BUS-1:0]                mem_addr_o,
  output logic [3:0]                         mem_width_o,
  output logic [DATA_BUS-1:0]                mem_data_o,
  input  logic [DATA_BUS-1:0]                mem_data_i,
  output logic                               timeout_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("table_mem_arbiter: unsupported NUM_REQ/MAX_HOLD");
  end

  typedef enum logic {ARB_IDLE = 1'b0, ARB_OWNED = 1'b1} arb_state_e;
  arb_state_e state, state_nxt;

  logic [IW-1:0]      owner, rr_ptr, pick, owner_inc;
  logic               pick_vld, owner_ce, revoke, release_own;
  logic [NUM_REQ-1:0] elig;

  assign owner_ce    = req_ce_i[owner];
  assign owner_inc   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign release_own = (state == ARB_OWNED) && (!owner_ce || revoke);

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    logic [IW:0] sum;
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (elig[sum[IW-1:0]]) begin
        pick     = sum[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]      hold_cnt;
  logic [NUM_REQ-1:0] blk_mask;
  logic               timeout_q;

  // Revoke on the edge where hold_cnt would reach MAX_HOLD: exactly MAX_HOLD owned cycles.
  assign revoke    = (state == ARB_OWNED) && owner_ce && (hold_cnt == HW'(MAX_HOLD - 1));
  assign elig      = req_ce_i & ~blk_mask;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      blk_mask  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ARB_IDLE && pick_vld)
        hold_cnt <= '0;
      else if (state == ARB_OWNED && hold_cnt != HW'(MAX_HOLD))
        hold_cnt <= hold_cnt + 1'b1;
      // A revoked requester stays masked until it drops its own ce.
      blk_mask <= (blk_mask & req_ce_i) | (revoke ? (NUM_REQ'(1) << owner) : '0);
      if (revoke) timeout_q <= 1'b1;
    end
  end
`else
  assign revoke    = 1'b0;
  assign elig      = req_ce_i;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_vld)    state_nxt = ARB_OWNED;
      ARB_OWNED: if (release_own) state_nxt = ARB_IDLE;
    endcase
  end

  // Idle always drives zeros, so async reset of state clears the memory port instantly.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    if (state == ARB_OWNED) begin
      mem_ce_o    = owner_ce;
      mem_we_o    = req_we_i[owner];
      mem_addr_o  = req_addr_i[owner];
      mem_width_o = req_width_i[owner];
      mem_data_o  = req_data_i[owner];
    end
  end

  assign rd_data_o = mem_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_o <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
    end else if (state == ARB_IDLE) begin
      if (pick_vld) begin
        grant_o <= NUM_REQ'(1) << pick;
        owner   <= pick;
      end
    end else if (release_own) begin
      grant_o <= '0;
      rr_ptr  <= owner_inc;
    end
  end

endmodule

// File: tb/tb_table_mem_arbiter.sv
// Randomized + directed bench for table_mem_arbiter against a cycle-level reference model.
// Watchdog expectations are active when ARB_WATCHDOG_EN is defined.
module tb_table_mem_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]          req_ce, req_we;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][3:0]     req_width;
  logic [N-1:0][DW-1:0]  req_data;
  logic [N-1:0]          grant;
  logic [DW-1:0]         rd_data, mem_data_in, mem_data;
  logic                  mem_ce, mem_we, timeout;
  logic [AW-1:0]         mem_addr;
  logic [3:0]            mem_width;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: owner index (-1 = idle), next-search start, owned cycles
  int m_owner, m_rr, m_cnt;
  bit m_to;
  bit m_blk[N];
  int rem[N];
  bit started[N];

  always #5 clk = ~clk;

  table_mem_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH), .ADDR_BUS(AW), .DATA_BUS(DW)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_width_i(req_width), .req_data_i(req_data),
    .grant_o(grant), .rd_data_o(rd_data),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_width_o(mem_width), .mem_data_o(mem_data),
    .mem_data_i(mem_data_in), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_cnt = 0; m_to = 1'b0;
    for (int i = 0; i < N; i++) m_blk[i] = 1'b0;
  endtask

  task automatic model_step();
    int c;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (req_ce[c] && !m_blk[c]) begin
          m_owner = c;
          m_cnt   = 0;
          break;
        end
      end
    end else if (!req_ce[m_owner]) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_cnt++;
`ifdef ARB_WATCHDOG_EN
      if (m_cnt == MH) begin
        m_to           = 1'b1;
        m_blk[m_owner] = 1'b1;
        m_rr           = (m_owner + 1) % N;
        m_owner        = -1;
      end
`endif
    end
    for (int i = 0; i < N; i++) if (!req_ce[i]) m_blk[i] = 1'b0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("grant", grant, eg);
    if (m_owner >= 0) begin
      chk("mem_ce", mem_ce, req_ce[m_owner]);
      chk("mem_we", mem_we, req_we[m_owner]);
      chk("mem_addr", mem_addr, req_addr[m_owner]);
      chk("mem_width", mem_width, req_width[m_owner]);
      chk("mem_data", mem_data, req_data[m_owner]);
    end else begin
      chk("idle_mem_ce", mem_ce, 1'b0);
      chk("idle_mem_we", mem_we, 1'b0);
      chk("idle_mem_addr", mem_addr, '0);
      chk("idle_mem_width", mem_width, '0);
      chk("idle_mem_data", mem_data, '0);
    end
    chk("rd_data", rd_data, mem_data_in);
    chk("timeout", timeout, m_to);
  endtask

  // one clock: drive at negedge, check 1 unit later, advance model at posedge
  task automatic cyc(input logic [N-1:0] cev);
    @(negedge clk);
    req_ce = cev;
    for (int i = 0; i < N; i++) begin
      req_we[i]    = 1'($urandom);
      req_addr[i]  = AW'($urandom);
      req_width[i] = 4'($urandom_range(1, 8));
      req_data[i]  = $urandom;
    end
    mem_data_in = $urandom;
    #1 check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic run(input logic [N-1:0] cev, input int n);
    repeat (n) cyc(cev);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_ce = '0;
    #1 model_reset();
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_grant", grant, '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_cyc();
    logic [N-1:0] cev;
    cev = req_ce;
    for (int i = 0; i < N; i++) begin
      if (!cev[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          cev[i] = 1'b1;
          rem[i] = $urandom_range(1, 12);
          started[i] = 1'b0;
        end
      end else begin
        if (m_owner == i) started[i] = 1'b1;
        if (started[i]) begin
          rem[i]--;
          if (rem[i] <= 0) cev[i] = 1'b0;
        end
      end
    end
    cyc(cev);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[$];
    int held;
    int gcnt;
    logic [N-1:0] cev;
    rst = 1'b0;
    req_ce = '0; req_we = '0; req_addr = '0; req_width = '0; req_data = '0;
    mem_data_in = '0;
    model_reset();
    #12;
    chk("reset_grant", grant, '0);
    chk("reset_mem_ce", mem_ce, 1'b0);
    chk("reset_timeout", timeout, 1'b0);
    chk("reset_mem_addr", mem_addr, '0);
    run('0, 2);
    @(negedge clk);
    rst = 1'b1;

    // single request
    run(4'b0001, 1);
    #2 chk("single_grant_t1", grant, 4'b0001);
    run(4'b0001, 4);
    run(4'b0000, 1);
    #2 chk("single_release", grant, 4'b0000);
    run(4'b0000, 1);

    // round-robin with all requesters, 3-cycle bursts
    do_reset();
    held = 0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      cev = '1;
      if (m_owner >= 0) begin
        if (held == 0) order.push_back(m_owner);
        held++;
        if (held > 3) cev[m_owner] = 1'b0;
      end else begin
        held = 0;
      end
      cyc(cev);
    end
    chk("rr_count", order.size(), 5);
    for (int k = 0; k < order.size(); k++) chk($sformatf("rr_order%0d", k), order[k], k % N);
    run('0, 2);

    // burst lock
    do_reset();
    run(4'b0100, 3);
    run(4'b0101, 3);
    #2 chk("lock_hold", grant, 4'b0100);
    run(4'b0001, 1);
    #2 chk("lock_release", grant, 4'b0000);
    run(4'b0001, 1);
    #2 chk("lock_next", grant, 4'b0001);
    run(4'b0000, 2);

    // wrap-around from rr_ptr = 3
    do_reset();
    run(4'b0100, 2);
    run(4'b0000, 2);
    run(4'b1001, 1);
    #2 chk("wrap_first", grant, 4'b1000);
    run(4'b1001, 2);
    run(4'b0001, 2);
    #2 chk("wrap_second", grant, 4'b0001);
    run(4'b0000, 2);

    // asynchronous reset mid-burst
    run(4'b0100, 3);
    #2 chk("async_pre_ce", mem_ce, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_mem_ce", mem_ce, 1'b0);
    chk("async_grant", grant, '0);
    model_reset();
    req_ce = '0;
    @(negedge clk);
    rst = 1'b1;
    run(4'b0010, 1);
    #2 chk("async_regrant", grant, 4'b0010);
    run(4'b0000, 2);

`ifdef ARB_WATCHDOG_EN
    do_reset();
    gcnt = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(4'b0010);
      #2 if (grant[1]) gcnt++;
    end
    run(4'b0000, 2);
    chk("wd_hold_cycles", gcnt, MH);
    chk("wd_timeout_sticky", timeout, 1'b1);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      started[i] = 1'b0;
    end
    repeat (2000) rand_cyc();
    run('0, 3);

    do_reset();
    chk("final_timeout", timeout, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/table_mem_arbiter.md
TABLE_MEM_ARBITER -- requirements
Module: table_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 64, watchdog limit in cycles per grant.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port req_ce_i, input, NUM_REQ, per-requester access request; held high for the whole burst.
REQ-006 SHALL have port req_we_i, input, NUM_REQ, per-requester write enable.
REQ-007 SHALL have port req_addr_i, input, NUM_REQ x ADDR_BUS, per-requester byte address.
REQ-008 SHALL have port req_width_i, input, NUM_REQ x 4, per-requester access width in bytes.
REQ-009 SHALL have port req_data_i, input, NUM_REQ x DATA_BUS, per-requester write data.
REQ-010 SHALL have port grant_o, input-side result, output, NUM_REQ, registered one-hot grant; at most one bit set.
REQ-011 SHALL have port rd_data_o, output, DATA_BUS, mem_data_i broadcast to all requesters.
REQ-012 SHALL have ports mem_ce_o / mem_we_o / mem_addr_o / mem_width_o / mem_data_o, output, 1 / 1 / ADDR_BUS / 4 / DATA_BUS, shared table-memory port.
REQ-013 SHALL have port mem_data_i, input, DATA_BUS, table-memory read data, valid 2 cycles after its address.
REQ-014 SHALL have port timeout_o, output, 1, sticky watchdog error flag.

Function
REQ-015 SHALL implement a two-state FSM: ARB_IDLE, ARB_OWNED.
REQ-016 In ARB_IDLE, if any req_ce_i bit is set, SHALL grant the first set bit at or after rr_ptr (modulo NUM_REQ), register it into grant_o, and move to ARB_OWNED.
REQ-017 Latency: req_ce_i rising in cycle t with the arbiter idle SHALL produce grant_o in cycle t+1.
REQ-018 In ARB_OWNED, mem_* outputs SHALL be a combinational mux of the owner's req_* signals; mem_ce_o = req_ce_i[owner].
REQ-019 In ARB_IDLE, mem_ce_o and mem_we_o SHALL be 0; mem_addr_o, mem_width_o, and mem_data_o SHALL be 0.
REQ-020 Grant is burst-locked: it SHALL persist while req_ce_i[owner] = 1, regardless of other requests.
REQ-021 When req_ce_i[owner] = 0 in ARB_OWNED, SHALL clear grant_o, set rr_ptr = owner+1 (wrapping NUM_REQ-1 -> 0), and return to ARB_IDLE.
REQ-022 Release-then-regrant SHALL have exactly one bubble cycle in ARB_IDLE, including when another requester is already waiting.
REQ-023 Non-owners' req_* inputs SHALL be ignored; requesters SHALL treat rd_data_o as valid only while granted.
REQ-024 hold_cnt SHALL clear on every grant, increment each ARB_OWNED cycle, and saturate at MAX_HOLD.

Reset
REQ-025 While rst = 0, SHALL asynchronously force the following: grant_o = 0, state = ARB_IDLE, rr_ptr = 0, hold_cnt = 0, timeout_o = 0, and all mem_* outputs = 0.
REQ-026 Reset asserted mid-burst SHALL drop mem_ce_o in the same cycle, without waiting for a clock edge.
REQ-027 After rst deasserts, arbitration SHALL resume on the first clk edge.

Configuration
REQ-028 Macro ARB_WATCHDOG_EN SHALL control the watchdog feature.
REQ-029 With ARB_WATCHDOG_EN defined: when hold_cnt reaches MAX_HOLD in ARB_OWNED, the arbiter SHALL forcibly revoke the grant (as in REQ-021), set timeout_o = 1 (sticky until reset), and ignore the revoked requester until its req_ce_i falls.
REQ-030 Without ARB_WATCHDOG_EN: hold_cnt logic SHALL be absent, grants SHALL be unbounded, and timeout_o SHALL be tied to 0.

Verification
REQ-031 Single request: req_ce_i = 0001 at cycle 0, held for 5 cycles -> grant_o = 0001 at cycle 1; mem_addr_o follows req_addr_i[0]; grant_o = 0000 the cycle after ce drops.
REQ-032 Round-robin: req_ce_i = 1111 held continuously, each burst 3 cycles -> grant order 0, 1, 2, 3, 0 with one idle cycle between grants.
REQ-033 Burst lock: requester 2 granted, then requester 0 raises ce -> grant_o stays 0100 until req_ce_i[2] falls; grant 0001 follows after one bubble.
REQ-034 Wrap-around: rr_ptr = 3, req_ce_i = 1001 -> requester 3 is granted first, then requester 0.
REQ-035 Async reset: rst pulled low mid-burst between clock edges -> mem_ce_o = 0 and grant_o = 0 immediately; after release, req_ce_i = 0010 yields grant 0010 one cycle later.
REQ-036 Watchdog (ARB_WATCHDOG_EN, MAX_HOLD = 8): requester 1 holds ce for 20 cycles -> grant revoked after 8 owned cycles, timeout_o = 1, requester 1 not regranted until its ce drops.
